alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback.sv | 78 +++++++
 tb/tb_alu_writeback.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// alu_writeback: registers ALU results into the register file and keeps the NZCV status register;
// long multiplies (UMULL/SMULL) are split into a low write followed by a high write.
module alu_writeback (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   output logic        ready_in,
   input  logic [31:0] Result1,
   input  logic [31:0] Result2,
   input  logic [3:0]  ALUFlags,
   input  logic [2:0]  ALUControl,
   input  logic [3:0]  Cond,
   input  logic [1:0]  FlagWrite,
   input  logic        RegWrite,
   input  logic [3:0]  RdLo,
   input  logic [3:0]  RdHi,
   output logic        rf_we,
   output logic [3:0]  rf_wa,
   output logic [31:0] rf_wd,
   output logic [3:0]  Flags,
   output logic        cond_ex
);
   typedef enum logic {IDLE, HI_PEND} state_t;
   state_t state, state_nx;
   logic n, z, c, v, ge, is_long, is_mul, take, wr_lo, wr_hi;
   logic [15:0] cond_tab;
   logic [1:0] nz_new;
   logic [3:0] flags_nx, hi_wa;
   logic [31:0] hi_wd;
   assign {n, z, c, v} = Flags;
   assign ge = n == v;
   // indexed by Cond: bit 0 is EQ, bit 15 is the never-execute encoding
   assign cond_tab = {1'b0, 1'b1, z | ~ge, ~z & ge, ~ge, ge, ~c | z, c & ~z,
                      ~v, v, ~n, n, ~c, c, ~z, z};
   assign cond_ex = cond_tab[Cond];
   assign is_long = ALUControl == 3'b101 || ALUControl == 3'b110;
   assign is_mul = ALUControl == 3'b100;
   assign ready_in = state == IDLE;
   assign take = valid_in & ready_in & cond_ex;
   assign wr_lo = take & RegWrite;
   assign wr_hi = wr_lo & is_long;
   assign nz_new = is_long ? {Result2[31], {Result2, Result1} == 64'd0} : ALUFlags[3:2];
   always_comb begin
      state_nx = IDLE;
      flags_nx = Flags;
      if (wr_hi) state_nx = HI_PEND;
      if (take & FlagWrite[1]) flags_nx[3:2] = nz_new;
      if (take & FlagWrite[0] & ~is_long & ~is_mul) flags_nx[1:0] = ALUFlags[1:0];
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rf_we <= 1'b0;
         rf_wa <= 4'd0;
         rf_wd <= 32'd0;
         Flags <= 4'd0;
         hi_wa <= 4'd0;
         hi_wd <= 32'd0;
      end else begin
         Flags <= flags_nx;
         rf_we <= wr_lo | (state == HI_PEND);
         if (state == HI_PEND) begin
            rf_wa <= hi_wa;
            rf_wd <= hi_wd;
         end else if (wr_lo) begin
            rf_wa <= RdLo;
            rf_wd <= Result1;
         end
         if (wr_hi) begin
            hi_wa <= RdHi;
            hi_wd <= Result2;
         end
      end
   end
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed scenarios plus random traffic against a queue-based write model.
module tb_alu_writeback;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic valid_in = 1'b0;
   logic ready_in;
   logic [31:0] Result1 = '0, Result2 = '0;
   logic [3:0] ALUFlags = '0, Cond = '0, RdLo = '0, RdHi = '0;
   logic [2:0] ALUControl = '0;
   logic [1:0] FlagWrite = '0;
   logic RegWrite = 1'b0;
   logic rf_we;
   logic [3:0] rf_wa, Flags;
   logic [31:0] rf_wd;
   logic cond_ex;
   int n_chk = 0, n_fail = 0;
   logic [35:0] q[$];
   logic [3:0] m_flags = '0, m_wa = '0;
   logic [31:0] m_wd = '0;

   alu_writeback dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
      .Result1(Result1), .Result2(Result2), .ALUFlags(ALUFlags), .ALUControl(ALUControl),
      .Cond(Cond), .FlagWrite(FlagWrite), .RegWrite(RegWrite), .RdLo(RdLo), .RdHi(RdHi),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .Flags(Flags), .cond_ex(cond_ex)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ARM style: base condition from Cond[3:1], inverted by Cond[0]
   function automatic logic m_cond(input logic [3:0] cd, input logic [3:0] f);
      logic nn, zz, cc, vv, b;
      {nn, zz, cc, vv} = f;
      case (cd[3:1])
         3'd0: b = zz;
         3'd1: b = cc;
         3'd2: b = nn;
         3'd3: b = vv;
         3'd4: b = cc && !zz;
         3'd5: b = nn == vv;
         3'd6: b = !zz && nn == vv;
         default: b = 1'b1;
      endcase
      return b ^ cd[0];
   endfunction

   task automatic drv(input logic vl, input logic [2:0] ctl, input logic [3:0] cd, input logic [1:0] fw,
                      input logic rw, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] af);
      valid_in = vl; ALUControl = ctl; Cond = cd; FlagWrite = fw; RegWrite = rw;
      Result1 = r1; Result2 = r2; RdLo = lo; RdHi = hi; ALUFlags = af;
   endtask

   task automatic step();
      logic pass, acc, lng;
      logic [63:0] prod;
      logic [35:0] e;
      #1;
      pass = m_cond(Cond, m_flags);
      acc = valid_in && q.size() == 0;
      lng = ALUControl == 3'd5 || ALUControl == 3'd6;
      prod = {Result2, Result1};
      chk("ready_in", 64'(ready_in), 64'(q.size() == 0));
      chk("cond_ex", 64'(cond_ex), 64'(pass));
      if (acc && pass) begin
         if (RegWrite) begin
            q.push_back({RdLo, Result1});
            if (lng) q.push_back({RdHi, Result2});
         end
         if (FlagWrite[1]) m_flags[3:2] = lng ? {prod[63], prod == 64'd0} : ALUFlags[3:2];
         if (FlagWrite[0] && !lng && ALUControl != 3'd4) m_flags[1:0] = ALUFlags[1:0];
      end
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         {m_wa, m_wd} = e;
         chk("rf_we", 64'(rf_we), 64'd1);
      end else chk("rf_we", 64'(rf_we), 64'd0);
      chk("rf_wa", 64'(rf_wa), 64'(m_wa));
      chk("rf_wd", 64'(rf_wd), 64'(m_wd));
      chk("Flags", 64'(Flags), 64'(m_flags));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      q.delete();
      m_flags = '0; m_wa = '0; m_wd = '0;
      chk("rst_we", 64'(rf_we), 64'd0);
      chk("rst_flags", 64'(Flags), 64'd0);
      chk("rst_wa_wd", {28'd0, rf_wa, rf_wd}, 64'd0);
      chk("rst_ready", 64'(ready_in), 64'd1);
      @(posedge clk);
      #1;
      chk("rst_hold_we", 64'(rf_we), 64'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #1;
      chk("por_we", 64'(rf_we), 64'd0);
      chk("por_flags", 64'(Flags), 64'd0);
      chk("por_ready", 64'(ready_in), 64'd1);
      @(negedge clk);
      reset = 1'b1;
      // ADD with always condition
      drv(1, 3'b000, 4'he, 2'b11, 1, 32'd5, 32'd0, 4'd3, 4'd0, 4'b0010);
      step();
      chk("add_wa", 64'(rf_wa), 64'd3);
      chk("add_wd", 64'(rf_wd), 64'd5);
      chk("add_flags", 64'(Flags), 64'b0010);
      // UMULL: two writes, N from high word
      drv(1, 3'b101, 4'he, 2'b10, 1, 32'd1, 32'h8000_0000, 4'd4, 4'd5, 4'b0000);
      step();
      chk("umull_lo", {28'd0, rf_wa, rf_wd}, {28'd0, 4'd4, 32'd1});
      chk("umull_busy", 64'(ready_in), 64'd0);
      drv(1, 3'b000, 4'he, 2'b11, 1, 32'hdead, 32'd0, 4'd9, 4'd0, 4'b1111);
      step();
      chk("umull_hi", {28'd0, rf_wa, rf_wd}, {28'd0, 4'd5, 32'h8000_0000});
      chk("umull_flags", 64'(Flags), 64'b1010);
      chk("umull_ready", 64'(ready_in), 64'd1);
      // set Z, then NE must fail
      drv(1, 3'b000, 4'he, 2'b10, 0, 32'd0, 32'd0, 4'd0, 4'd0, 4'b0100);
      step();
      drv(1, 3'b010, 4'h1, 2'b11, 1, 32'd7, 32'd0, 4'd2, 4'd0, 4'b1011);
      step();
      chk("ne_skip_we", 64'(rf_we), 64'd0);
      chk("ne_skip_flags", 64'(Flags), 64'b0110);
      // SMULL zero result sets Z, then EQ executes
      drv(1, 3'b110, 4'he, 2'b10, 1, 32'd0, 32'd0, 4'd6, 4'd7, 4'b1000);
      step();
      drv(0, 3'b000, 4'he, 2'b00, 0, 32'd0, 32'd0, 4'd0, 4'd0, 4'b0000);
      step();
      chk("smull_flags", 64'(Flags), 64'b0110);
      drv(1, 3'b000, 4'h0, 2'b00, 1, 32'h11, 32'd0, 4'd8, 4'd0, 4'b0000);
      step();
      chk("eq_we", 64'(rf_we), 64'd1);
      // back-to-back ORs
      for (int i = 1; i <= 3; i++) begin
         drv(1, 3'b011, 4'he, 2'b00, 1, 32'(i * 16), 32'd0, 4'(i), 4'd0, 4'b0000);
         step();
         chk("or_b2b", {27'd0, rf_we, rf_wa, 32'd0}, {27'd0, 1'b1, 4'(i), 32'd0});
      end
      // RdLo == RdHi: high word lands last
      drv(1, 3'b101, 4'he, 2'b00, 1, 32'h1234, 32'h5678, 4'd10, 4'd10, 4'b0000);
      step();
      drv(0, 3'b000, 4'he, 2'b00, 0, 32'd0, 32'd0, 4'd0, 4'd0, 4'b0000);
      step();
      chk("same_rd_final", {28'd0, rf_wa, rf_wd}, {28'd0, 4'd10, 32'h5678});
      // reset while the high write is pending
      drv(1, 3'b101, 4'he, 2'b11, 1, 32'd3, 32'd4, 4'd1, 4'd2, 4'b0000);
      step();
      do_reset();
      drv(0, 3'b000, 4'he, 2'b00, 0, 32'd0, 32'd0, 4'd0, 4'd0, 4'b0000);
      step();
      chk("no_hi_after_rst", 64'(rf_we), 64'd0);
      for (int i = 0; i < 500; i++) begin
         drv($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
             ($urandom_range(0, 2) == 0) ? 4'he : 4'($urandom),
             2'($urandom), $urandom_range(0, 3) != 0,
             ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
             ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
             4'($urandom), 4'($urandom), 4'($urandom));
         step();
         if ($urandom_range(0, 59) == 0) do_reset();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
